spcm_slave_responder: RTL

//  SPI mode-0 slave that answers a serial-PCM/flash master (the SPCM core) on its own wires.

---
 rtl/spcm_pkg.sv | 39 +++
 rtl/spi_sync_edge.sv | 51 +++++
 rtl/spcm_slave_responder.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spcm_pkg.sv
// Shared definitions for the SPCM slave responder.
//  - SPI opcodes understood by the responder (READ, RDSR, RDID).
//  - FSM state encoding and the response-source selector.
//  - rdid_byte(): picks the RDID response byte for a given byte index.
package spcm_pkg;

    localparam logic [7:0] SPCM_CMD_READ = 8'h03;
    localparam logic [7:0] SPCM_CMD_RDSR = 8'h05;
    localparam logic [7:0] SPCM_CMD_RDID = 8'h9F;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_RESP   = 3'd4,
        ST_IGNORE = 3'd5
    } spcm_state_e;

    typedef enum logic {
        RESP_RDSR = 1'b0,
        RESP_RDID = 1'b1
    } spcm_resp_e;

    // RDID sends the three ID bytes MSB first, then zeros for as long as
    // the master keeps clocking. Index saturates at 3.
    function automatic logic [7:0] rdid_byte(input logic [23:0] dev_id,
                                             input logic [1:0]  idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = dev_id[23:16];
            2'd1:    b = dev_id[15:8];
            2'd2:    b = dev_id[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizers for the asynchronous SPI pins plus edge pulses.
// Ports:
//  clk, rst_n          system clock, async active-low reset
//  cs_n_i/sck_i/mosi_i raw SPI pins from the master
//  cs_n_s, mosi_s      synchronized CS_N and MOSI levels
//  sck_rise, sck_fall  one-cycle pulses on synchronized SCK edges
//  cs_fall             one-cycle pulse when synchronized CS_N goes low
module spi_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic cs_n_i,
    input  logic sck_i,
    input  logic mosi_i,
    output logic cs_n_s,
    output logic mosi_s,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_fall
);

    // [0] = first stage, [1] = synchronized level, [2] = previous level
    logic [2:0] cs_q,   cs_d;
    logic [2:0] sck_q,  sck_d;
    logic [1:0] mosi_q, mosi_d;

    always_comb begin
        cs_d   = {cs_q[1],   cs_q[0],   cs_n_i};
        sck_d  = {sck_q[1],  sck_q[0],  sck_i};
        mosi_d = {mosi_q[0], mosi_i};
    end

    // CS_N resets deasserted (high), SCK to its idle level (low).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q   <= 3'b111;
            sck_q  <= 3'b000;
            mosi_q <= 2'b00;
        end else begin
            cs_q   <= cs_d;
            sck_q  <= sck_d;
            mosi_q <= mosi_d;
        end
    end

    assign cs_n_s   = cs_q[1];
    assign mosi_s   = mosi_q[1];
    assign sck_rise =  sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] &  sck_q[2];
    assign cs_fall  = ~cs_q[1]  &  cs_q[2];

endmodule

// File: rtl/spcm_slave_responder.sv
// SPI mode-0 slave answering READ / RDSR / RDID from an SPCM master.
// Ports:
//  clk, rst_n                  system clock, async active-low reset
//  spcm_cs_n/sck/mosi          SPI inputs (asynchronous to clk)
//  spcm_miso, spcm_miso_oe     SPI output and its drive enable
//  mem_req/addr/ack/din        byte fetch port (req held until ack)
//  status_busy                 bit0 of the RDSR response
//  active                      transaction in progress
//  underrun                    sticky: a READ byte was due before its fetch completed
//
// Handshake: mem_req rises with a stable mem_addr and stays high until the
// cycle in which mem_ack is seen; that cycle transfers mem_din. At most one
// request is outstanding. A fetch that completes after CS_N rises is dropped.
module spcm_slave_responder
    import spcm_pkg::*;
#(
    parameter int          CLK_FREQ  = 100,
    parameter int          ADDR_BITS = 24,
    parameter logic [23:0] DEV_ID    = 24'h20BA18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 spcm_cs_n,
    input  logic                 spcm_sck,
    input  logic                 spcm_mosi,
    output logic                 spcm_miso,
    output logic                 spcm_miso_oe,
    output logic                 mem_req,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic [7:0]           mem_din,
    input  logic                 status_busy,
    output logic                 active,
    output logic                 underrun
);

    localparam int ADDR_BYTES = ADDR_BITS / 8;
    localparam int AB_W       = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;

    // The oversampling edge detector needs at least 4 clk per SCK phase.
    if (CLK_FREQ < 8) begin : g_clk_check
        $error("spcm_slave_responder: CLK_FREQ too low for SCK oversampling");
    end

    logic cs_n_s, mosi_s, sck_rise, sck_fall, cs_fall;

    spi_sync_edge u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs_n_i   (spcm_cs_n),
        .sck_i    (spcm_sck),
        .mosi_i   (spcm_mosi),
        .cs_n_s   (cs_n_s),
        .mosi_s   (mosi_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_fall  (cs_fall)
    );

    spcm_state_e          state_q,     state_d;
    logic [2:0]           bit_cnt_q,   bit_cnt_d;
    logic [AB_W-1:0]      addr_byte_q, addr_byte_d;
    logic [ADDR_BITS-1:0] rx_q,        rx_d;
    logic [7:0]           tx_q,        tx_d;
    logic                 miso_q,      miso_d;
    logic                 oe_q,        oe_d;
    logic                 bnd_pend_q,  bnd_pend_d;   // byte boundary due at next SCK fall
    logic [7:0]           buf_q,       buf_d;        // prefetched READ byte
    logic                 buf_valid_q, buf_valid_d;
    logic                 mem_req_q,   mem_req_d;
    logic [ADDR_BITS-1:0] mem_addr_q,  mem_addr_d;
    logic                 underrun_q,  underrun_d;
    spcm_resp_e           resp_kind_q, resp_kind_d;
    logic [1:0]           rdid_idx_q,  rdid_idx_d;

    logic                 byte_last;
    logic [ADDR_BITS-1:0] rx_next;
    logic [7:0]           resp_byte;

    always_comb begin
        byte_last = sck_rise && (bit_cnt_q == 3'd7);
        rx_next   = {rx_q[ADDR_BITS-2:0], mosi_s};
        resp_byte = (resp_kind_q == RESP_RDSR) ? {7'b0, status_busy}
                                               : rdid_byte(DEV_ID, rdid_idx_q);
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        addr_byte_d = addr_byte_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        oe_d        = oe_q;
        bnd_pend_d  = bnd_pend_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        underrun_d  = underrun_q;
        resp_kind_d = resp_kind_q;
        rdid_idx_d  = rdid_idx_q;

        // A completing fetch always closes the request; its data is only
        // kept while a READ is streaming.
        if (mem_req_q && mem_ack) begin
            mem_req_d = 1'b0;
            if (state_q == ST_DATA) begin
                buf_d       = mem_din;
                buf_valid_d = 1'b1;
                mem_addr_d  = mem_addr_q + ADDR_BITS'(1);
            end
        end

        if (state_q == ST_IDLE) begin
            if (cs_fall) begin
                state_d     = ST_CMD;
                underrun_d  = 1'b0;
                bit_cnt_d   = 3'd0;
                addr_byte_d = '0;
                bnd_pend_d  = 1'b0;
                buf_valid_d = 1'b0;
            end
        end else if (cs_n_s) begin
            // Deselect wins over everything; any partial byte is dropped.
            state_d     = ST_IDLE;
            oe_d        = 1'b0;
            miso_d      = 1'b1;
            bnd_pend_d  = 1'b0;
            buf_valid_d = 1'b0;
            bit_cnt_d   = 3'd0;
        end else begin
            if (sck_rise) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                rx_d      = rx_next;
            end
            case (state_q)
                ST_CMD: begin
                    if (byte_last) begin
                        case (rx_next[7:0])
                            SPCM_CMD_READ: begin
                                state_d     = ST_ADDR;
                                addr_byte_d = '0;
                            end
                            SPCM_CMD_RDSR: begin
                                state_d     = ST_RESP;
                                resp_kind_d = RESP_RDSR;
                                bnd_pend_d  = 1'b1;
                            end
                            SPCM_CMD_RDID: begin
                                state_d     = ST_RESP;
                                resp_kind_d = RESP_RDID;
                                rdid_idx_d  = 2'd0;
                                bnd_pend_d  = 1'b1;
                            end
                            default: state_d = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (byte_last) begin
                        if (addr_byte_q == AB_W'(ADDR_BYTES - 1)) begin
                            // rx holds exactly the address bits by now
                            mem_addr_d  = rx_next;
                            mem_req_d   = 1'b1;
                            buf_valid_d = 1'b0;
                            bnd_pend_d  = 1'b1;
                            state_d     = ST_DATA;
                        end else begin
                            addr_byte_d = addr_byte_q + AB_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (byte_last) begin
                        bnd_pend_d = 1'b1;
                    end else if (sck_fall) begin
                        if (bnd_pend_q) begin
                            bnd_pend_d = 1'b0;
                            oe_d       = 1'b1;
                            if (buf_valid_q) begin
                                tx_d        = buf_q;
                                miso_d      = buf_q[7];
                                buf_valid_d = 1'b0;
                                mem_req_d   = 1'b1;
                            end else begin
                                // Fetch late: pad with FF, leave request pending.
                                tx_d       = 8'hFF;
                                miso_d     = 1'b1;
                                underrun_d = 1'b1;
                            end
                        end else begin
                            tx_d   = {tx_q[6:0], 1'b1};
                            miso_d = tx_q[6];
                        end
                    end
                end
                ST_RESP: begin
                    if (byte_last) begin
                        bnd_pend_d = 1'b1;
                    end else if (sck_fall) begin
                        if (bnd_pend_q) begin
                            bnd_pend_d = 1'b0;
                            oe_d       = 1'b1;
                            tx_d       = resp_byte;
                            miso_d     = resp_byte[7];
                            if (rdid_idx_q != 2'd3) begin
                                rdid_idx_d = rdid_idx_q + 2'd1;
                            end
                        end else begin
                            tx_d   = {tx_q[6:0], 1'b1};
                            miso_d = tx_q[6];
                        end
                    end
                end
                default: ;  // ST_IGNORE: wait for deselect
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            addr_byte_q <= '0;
            rx_q        <= '0;
            tx_q        <= 8'hFF;
            miso_q      <= 1'b1;
            oe_q        <= 1'b0;
            bnd_pend_q  <= 1'b0;
            buf_q       <= 8'h00;
            buf_valid_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            underrun_q  <= 1'b0;
            resp_kind_q <= RESP_RDSR;
            rdid_idx_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            addr_byte_q <= addr_byte_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            bnd_pend_q  <= bnd_pend_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            underrun_q  <= underrun_d;
            resp_kind_q <= resp_kind_d;
            rdid_idx_q  <= rdid_idx_d;
        end
    end

    assign spcm_miso    = miso_q;
    assign spcm_miso_oe = oe_q;
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign underrun     = underrun_q;
    assign active       = (state_q != ST_IDLE);

endmodule
